// File: rtl/fifo_width_upsizer.sv
// fifo_width_upsizer: pops IN_W-bit words from a 1-cycle-latency FIFO and packs RATIO of them
// into one valid/ready output beat. Define FIFO_UPSIZER_FLUSH_EN for partial-beat flush with keep mask.
module fifo_width_upsizer #(
  parameter  int IN_W  = 32,
  parameter  int RATIO = 4,
  localparam int OUT_W = IN_W * RATIO
) (
  input  logic             clk_100m,
  input  logic             rst,
  input  logic [IN_W-1:0]  fifo_rd_data,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic             blk_state_WRITE,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic [RATIO-1:0] out_keep,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(RATIO + 1);

  typedef enum logic {FILL, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   fill_cnt, total, hcnt;
  logic            pend, out_free, flush_req, room, handoff, discard;
  logic [IN_W-1:0] lanes     [RATIO];
  logic [IN_W-1:0] lanes_nxt [RATIO];

`ifdef FIFO_UPSIZER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
  logic wr_d;

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) wr_d <= 1'b0;
    else     wr_d <= blk_state_WRITE;
  end

  assign flush_req = flush | (wr_d & ~blk_state_WRITE);
`else
  localparam bit FLUSH_EN = 1'b0;
  logic unused_flush;

  assign unused_flush = flush;
  assign flush_req    = 1'b0;
`endif

  assign total    = fill_cnt + CW'(pend);
  assign out_free = ~out_valid | out_ready;

  // Capture stage: the word landing this cycle is merged into its lane before handoff
  always_comb begin
    for (int k = 0; k < RATIO; k++)
      lanes_nxt[k] = (pend && fill_cnt == CW'(k)) ? fifo_rd_data : lanes[k];
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    handoff    = 1'b0;
    hcnt       = '0;
    discard    = 1'b0;
    room       = 1'b0;
    case (state)
      FILL: begin
        // A full buffer may still accept a read if it hands off to the output this cycle
        room = (total < CW'(RATIO)) || (total == CW'(RATIO) && pend && out_free);
        fifo_rd_en = ~rst & ~flush_req & blk_state_WRITE & ~fifo_empty & room;
        if (total == CW'(RATIO) && out_free) begin
          handoff = 1'b1;
          hcnt    = CW'(RATIO);
        end else if (!FLUSH_EN && !blk_state_WRITE && !pend && fill_cnt != CW'(RATIO)) begin
          discard = 1'b1;
        end
        if (flush_req) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!pend) begin
          if (fill_cnt == '0) begin
            state_nxt = FILL;
          end else if (out_free) begin
            handoff   = 1'b1;
            hcnt      = fill_cnt;
            state_nxt = FILL;
          end
        end else if (total == CW'(RATIO) && out_free) begin
          handoff = 1'b1;
          hcnt    = CW'(RATIO);
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_100m) begin
    for (int k = 0; k < RATIO; k++)
      lanes[k] <= lanes_nxt[k];
  end

  // Output stage: lanes at or above hcnt are zeroed so partial beats carry no stale data
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      fill_cnt  <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= fifo_rd_en;
      if (handoff || discard) fill_cnt <= '0;
      else if (pend)          fill_cnt <= fill_cnt + CW'(1);
      if (handoff) begin
        out_valid <= 1'b1;
        for (int k = 0; k < RATIO; k++) begin
          out_data[k*IN_W +: IN_W] <= (CW'(k) < hcnt) ? lanes_nxt[k] : '0;
          out_keep[k]              <= (CW'(k) < hcnt);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_width_upsizer.sv
// Directed bench for fifo_width_upsizer (IN_W=32, RATIO=4) with a 1-cycle-latency FIFO model.
// Expectations follow FIFO_UPSIZER_FLUSH_EN when it is defined for the build.
module tb_fifo_width_upsizer;

  localparam int IN_W  = 32;
  localparam int RATIO = 4;
  localparam int OUT_W = 128;

  logic             clk_100m = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  fifo_rd_data;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic             blk_state_WRITE;
  logic             flush;
  logic [OUT_W-1:0] out_data;
  logic [RATIO-1:0] out_keep;
  logic             out_valid;
  logic             out_ready;

  fifo_width_upsizer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk_100m        (clk_100m),
    .rst             (rst),
    .fifo_rd_data    (fifo_rd_data),
    .fifo_empty      (fifo_empty),
    .fifo_rd_en      (fifo_rd_en),
    .blk_state_WRITE (blk_state_WRITE),
    .flush           (flush),
    .out_data        (out_data),
    .out_keep        (out_keep),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  always #5 clk_100m = ~clk_100m;

  logic [IN_W-1:0] mem [0:255];
  int unsigned     wr_ptr = 0;
  int unsigned     rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk_100m) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  logic [OUT_W-1:0] bdata [0:63];
  logic [RATIO-1:0] bkeep [0:63];
  int               bcyc  [0:63];
  int               nb  = 0;
  int               cyc = 0;

  always @(posedge clk_100m) cyc <= cyc + 1;

  always @(negedge clk_100m) begin
    #2;
    if (out_valid && out_ready && nb < 64) begin
      bdata[nb] <= out_data;
      bkeep[nb] <= out_keep;
      bcyc[nb]  <= cyc;
      nb        <= nb + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_100m);
  endtask

  task automatic push(input logic [IN_W-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic [OUT_W-1:0] pack4(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  int base, base2, hi;
  int unsigned rp0;

  initial begin
    rst = 1'b1; blk_state_WRITE = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick(2); #1;
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_data",  out_data,        128'd0);
    check("rst_keep",  128'(out_keep),  128'd0);
    check("rst_rden",  128'(fifo_rd_en), 128'd0);
    tick; rst = 1'b0;

    // full beat latency
    out_ready = 1'b1;
    push(32'h11111111); push(32'h22222222); push(32'h33333333); push(32'h44444444);
    base = nb;
    tick; blk_state_WRITE = 1'b1; #1;
    check("t1_rden_c0", 128'(fifo_rd_en), 128'd1);
    for (int c = 1; c <= 6; c++) begin
      tick; #1;
      check($sformatf("t1_rden_c%0d", c),  128'(fifo_rd_en), (c <= 3) ? 128'd1 : 128'd0);
      check($sformatf("t1_valid_c%0d", c), 128'(out_valid),  (c == 5) ? 128'd1 : 128'd0);
      if (c == 5) begin
        check("t1_data", out_data, 128'h44444444_33333333_22222222_11111111);
        check("t1_keep", 128'(out_keep), 128'hF);
      end
    end
    check("t1_nbeats", 128'(nb - base), 128'd1);

    // streaming 16 words
    tick;
    base = nb;
    for (int i = 0; i < 16; i++) push(32'hA0000000 + 32'(i));
    #1; hi = int'(fifo_rd_en);
    for (int c = 1; c < 16; c++) begin tick; #1; hi += int'(fifo_rd_en); end
    check("t2_rden_cycles", 128'(hi), 128'd16);
    tick; #1;
    check("t2_rden_after", 128'(fifo_rd_en), 128'd0);
    tick(3);
    check("t2_nbeats", 128'(nb - base), 128'd4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("t2_beat%0d", j), bdata[base+j],
            pack4(32'hA0000000 + 32'(4*j), 32'hA0000000 + 32'(4*j+1),
                  32'hA0000000 + 32'(4*j+2), 32'hA0000000 + 32'(4*j+3)));
      if (j > 0) check($sformatf("t2_gap%0d", j), 128'(bcyc[base+j] - bcyc[base+j-1]), 128'd4);
    end

    // backpressure with 12 queued words
    tick;
    out_ready = 1'b0;
    rp0 = rd_ptr;
    for (int i = 0; i < 12; i++) push(32'hB0000000 + 32'(i));
    tick(12); #1;
    check("t3_rden_stall", 128'(fifo_rd_en), 128'd0);
    check("t3_valid_hold", 128'(out_valid), 128'd1);
    check("t3_data_hold",  out_data, 128'hB0000003_B0000002_B0000001_B0000000);
    check("t3_fill_cnt",   128'(dut.fill_cnt), 128'd4);
    check("t3_reads",      128'(rd_ptr - rp0), 128'd8);
    tick(3); #1;
    check("t3_data_stable", out_data, 128'hB0000003_B0000002_B0000001_B0000000);
    tick;
    base = nb;
    out_ready = 1'b1;
    tick(12);
    check("t3_nbeats", 128'(nb - base), 128'd3);
    check("t3_beat0", bdata[base],   128'hB0000003_B0000002_B0000001_B0000000);
    check("t3_beat1", bdata[base+1], 128'hB0000007_B0000006_B0000005_B0000004);
    check("t3_beat2", bdata[base+2], 128'hB000000B_B000000A_B0000009_B0000008);
    check("t3_keep2", 128'(bkeep[base+2]), 128'hF);

    // enable drops after 2 words with a third read pending
    base = nb;
    for (int i = 0; i < 5; i++) push(32'hC0000000 + 32'(i));
    tick(3);
    blk_state_WRITE = 1'b0; #1;
    check("t4_rden_blocked", 128'(fifo_rd_en), 128'd0);
    tick(4);
`ifdef FIFO_UPSIZER_FLUSH_EN
    check("t4_nbeats", 128'(nb - base), 128'd1);
    check("t4_keep",   128'(bkeep[base]), 128'h7);
    check("t4_data",   bdata[base], 128'h00000000_C0000002_C0000001_C0000000);
`else
    check("t4_nbeats",   128'(nb - base), 128'd0);
    check("t4_fill_cnt", 128'(dut.fill_cnt), 128'd0);
`endif
    base2 = nb;
    push(32'hD0000000); push(32'hD0000001);
    blk_state_WRITE = 1'b1;
    tick(8);
    check("t4_next_nbeats", 128'(nb - base2), 128'd1);
    check("t4_next_data",   bdata[base2], 128'hD0000001_D0000000_C0000004_C0000003);
    check("t4_next_keep",   128'(bkeep[base2]), 128'hF);

    // flush after 3 words
    tick;
    base = nb;
    push(32'hE0000000); push(32'hE0000001); push(32'hE0000002);
    tick(4);
    flush = 1'b1;
    tick; flush = 1'b0;
    tick(3);
`ifdef FIFO_UPSIZER_FLUSH_EN
    check("t5_nbeats", 128'(nb - base), 128'd1);
    check("t5_keep",   128'(bkeep[base]), 128'h7);
    check("t5_data",   bdata[base], 128'h00000000_E0000002_E0000001_E0000000);
    base2 = nb;
    for (int i = 0; i < 4; i++) push(32'hF0000000 + 32'(i));
    tick(8);
    check("t5_next_data", bdata[base2], 128'hF0000003_F0000002_F0000001_F0000000);
`else
    check("t5_nbeats", 128'(nb - base), 128'd0);
    base2 = nb;
    push(32'hF0000000);
    tick(6);
    check("t5_next_data", bdata[base2], 128'hF0000000_E0000002_E0000001_E0000000);
`endif
    check("t5_next_keep", 128'(bkeep[base2]), 128'hF);

    // flush on an empty buffer emits nothing
    base = nb;
    flush = 1'b1;
    tick; flush = 1'b0;
    tick(4);
    check("t5_idle_flush", 128'(nb - base), 128'd0);

    // flush coinciding with a read opportunity
    base = nb;
    for (int i = 0; i < 4; i++) push(32'h60000000 + 32'(i));
    flush = 1'b1; #1;
`ifdef FIFO_UPSIZER_FLUSH_EN
    check("t5_flush_blocks_rd", 128'(fifo_rd_en), 128'd0);
`else
    check("t5_flush_ignored_rd", 128'(fifo_rd_en), 128'd1);
`endif
    tick; flush = 1'b0;
    tick(10);
    check("t5_after_flush_data", bdata[base], 128'h60000003_60000002_60000001_60000000);

    // async reset mid-beat
    tick;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(32'h70000000 + 32'(i));
    tick(6); #1;
    check("t6_pre_valid", 128'(out_valid), 128'd1);
    check("t6_pre_rden",  128'(fifo_rd_en), 128'd1);
    #2; rst = 1'b1; #1;
    check("t6_rst_valid", 128'(out_valid), 128'd0);
    check("t6_rst_data",  out_data, 128'd0);
    check("t6_rst_keep",  128'(out_keep), 128'd0);
    check("t6_rst_rden",  128'(fifo_rd_en), 128'd0);
    tick; blk_state_WRITE = 1'b0;
    tick; rst = 1'b0;
    wr_ptr = rd_ptr;
    out_ready = 1'b1;
    base = nb;
    push(32'h80000000); push(32'h80000001); push(32'h80000002); push(32'h80000003);
    blk_state_WRITE = 1'b1;
    tick(8);
    check("t6_nbeats", 128'(nb - base), 128'd1);
    check("t6_data",   bdata[base], 128'h80000003_80000002_80000001_80000000);
    check("t6_keep",   128'(bkeep[base]), 128'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
